decode_order_arbiter: RTL

In-order issue sequencer sitting in front of the decode mux. It shares the single decode-mux output slot between the A, B and D format decoders. Each cycle it grants at most one format, and only the one holding the next expected instruction (major ID plus micro-op minor ID). Program order is therefore preserved even though the format decoders finish independently. The block also detects ordering hangs and duplicate claims, and recovers on flush.

---
 rtl/decode_order_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/decode_order_arbiter.sv
// In-order issue sequencer for the shared decode-mux slot. It grants at most one of the
// A/B/D format decoders per cycle, and only the one holding the next expected major/minor ID.

module decode_order_match #(
    parameter int majW = 64,
    parameter int minW = 7
) (
    input  logic            req,
    input  logic [majW-1:0] majId,
    input  logic [minW-1:0] minId,
    input  logic [minW-1:0] numMicroOps,
    input  logic [majW-1:0] expMajId,
    input  logic [minW-1:0] expMinId,
    output logic            match,
    output logic            lastUop
);
    logic [minW:0] minPlusOne;
    logic [minW:0] uopCount;

    // Widened by one bit so that minId all-ones cannot wrap onto a valid count
    assign minPlusOne = {1'b0, minId} + (minW+1)'(1);
    assign uopCount   = (numMicroOps == '0) ? (minW+1)'(1) : {1'b0, numMicroOps};
    assign match      = req && (majId == expMajId) && (minId == expMinId);
    assign lastUop    = (minPlusOne == uopCount);
endmodule

module decode_order_arbiter #(
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int timeoutCycles           = 15,
    parameter int timeoutWidth            = 4
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               Areq_i,
    input  logic                               Breq_i,
    input  logic                               Dreq_i,
    input  logic [instructionCounterWidth-1:0] AMajId_i,
    input  logic [instructionCounterWidth-1:0] BMajId_i,
    input  logic [instructionCounterWidth-1:0] DMajId_i,
    input  logic [instMinIdWidth-1:0]          AMinId_i,
    input  logic [instMinIdWidth-1:0]          BMinId_i,
    input  logic [instMinIdWidth-1:0]          DMinId_i,
    input  logic [instMinIdWidth-1:0]          AnumMicroOps_i,
    input  logic [instMinIdWidth-1:0]          BnumMicroOps_i,
    input  logic [instMinIdWidth-1:0]          DnumMicroOps_i,
    input  logic                               stall_i,
    input  logic                               flush_i,
    input  logic [instructionCounterWidth-1:0] flushMajId_i,
    output logic                               Aenable_o,
    output logic                               Benable_o,
    output logic                               Denable_o,
    output logic [instructionCounterWidth-1:0] nextMajId_o,
    output logic [instMinIdWidth-1:0]          nextMinId_o,
    output logic                               hung_o,
    output logic                               dupErr_o
);
    localparam int NUM_LANES = 3;  // lane 0 = A (highest priority), 1 = B, 2 = D

    typedef enum logic {RUN, HUNG} arbState_e;

    arbState_e                             state_q, state_d;
    logic [instructionCounterWidth-1:0]    nextMajId_q, nextMajId_d;
    logic [instMinIdWidth-1:0]             nextMinId_q, nextMinId_d;
    logic [timeoutWidth-1:0]               waitCnt_q, waitCnt_d, waitCntInc;
    logic                                  dupErr_q, dupErr_d;

    logic [NUM_LANES-1:0]                              laneReq, laneMatch, laneLast, grant;
    logic [NUM_LANES-1:0][instructionCounterWidth-1:0] laneMajId;
    logic [NUM_LANES-1:0][instMinIdWidth-1:0]          laneMinId, laneNum;
    logic                                              grantOk, grantLast, found;

    assign laneReq   = {Dreq_i, Breq_i, Areq_i};
    assign laneMajId = {DMajId_i, BMajId_i, AMajId_i};
    assign laneMinId = {DMinId_i, BMinId_i, AMinId_i};
    assign laneNum   = {DnumMicroOps_i, BnumMicroOps_i, AnumMicroOps_i};

    for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
        decode_order_match #(
            .majW(instructionCounterWidth),
            .minW(instMinIdWidth)
        ) uMatch (
            .req        (laneReq[i]),
            .majId      (laneMajId[i]),
            .minId      (laneMinId[i]),
            .numMicroOps(laneNum[i]),
            .expMajId   (nextMajId_q),
            .expMinId   (nextMinId_q),
            .match      (laneMatch[i]),
            .lastUop    (laneLast[i])
        );
    end

    assign grantOk = (state_q == RUN) && !stall_i && !flush_i;

    always_comb begin
        grant     = '0;
        grantLast = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (grantOk && laneMatch[i] && !found) begin
                grant[i]  = 1'b1;
                grantLast = laneLast[i];
                found     = 1'b1;
            end
        end
    end

    assign waitCntInc = waitCnt_q + timeoutWidth'(1);

    always_comb begin
        state_d     = state_q;
        nextMajId_d = nextMajId_q;
        nextMinId_d = nextMinId_q;
        waitCnt_d   = waitCnt_q;
        dupErr_d    = dupErr_q || ($countones(laneMatch) > 1);
        if (flush_i) begin
            state_d     = RUN;
            nextMajId_d = flushMajId_i;
            nextMinId_d = '0;
            waitCnt_d   = '0;
        end else if (state_q == RUN) begin
            if (found) begin
                waitCnt_d = '0;
                if (grantLast) begin
                    nextMajId_d = nextMajId_q + instructionCounterWidth'(1);
                    nextMinId_d = '0;
                end else begin
                    nextMinId_d = nextMinId_q + instMinIdWidth'(1);
                end
            end else if (stall_i) begin
                waitCnt_d = waitCnt_q;
            end else if (|laneReq) begin
                // Not stalled and nothing granted means every request is unmatched
                if (waitCntInc == timeoutWidth'(timeoutCycles)) begin
                    state_d   = HUNG;
                    waitCnt_d = '0;
                end else begin
                    waitCnt_d = waitCntInc;
                end
            end else begin
                waitCnt_d = '0;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= RUN;
            nextMajId_q <= '0;
            nextMinId_q <= '0;
            waitCnt_q   <= '0;
            dupErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            nextMajId_q <= nextMajId_d;
            nextMinId_q <= nextMinId_d;
            waitCnt_q   <= waitCnt_d;
            dupErr_q    <= dupErr_d;
        end
    end

    assign Aenable_o   = grant[0];
    assign Benable_o   = grant[1];
    assign Denable_o   = grant[2];
    assign nextMajId_o = nextMajId_q;
    assign nextMinId_o = nextMinId_q;
    assign hung_o      = (state_q == HUNG);
    assign dupErr_o    = dupErr_q;
endmodule
